// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/size/response encodings and slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Wait-state counter width (covers 0..15 wait states).
    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-port bundle.
//  master modport: drives address/control/write data and the bus-wide hready.
//  slave  modport: returns hreadyout, hresp, hrdata.
interface ahb_sram_slave_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_array.sv
// DEPTH x DW word array: asynchronous read, synchronous byte-enabled write.
//  clk   : write clock
//  we    : write enable
//  be    : per-byte write enables (little-endian lanes)
//  addr  : shared read/write word index
//  wdata : write data
//  rdata : combinational read data
module ahb_sram_array #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DW/8-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);
    localparam int unsigned NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Byte-lane write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: captures address phases, inserts WAIT_STATES wait cycles per OKAY
// data phase, answers illegal size/alignment with the two-cycle ERROR response.
//  hclk   : bus clock
//  hreset : synchronous active-high reset
//  bus    : AHB slave port (hsel/haddr/htrans/hwrite/hsize/hburst/hwdata/hready in,
//           hreadyout/hresp/hrdata out)
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_sram_slave_if.slave   bus
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned LB = $clog2(NB);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = WAIT_CNT_W;
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

    slv_state_e    state, state_n, launch_state;
    logic [CW-1:0] cnt, cnt_n, launch_cnt;
    logic [AW-1:0] reg_haddr;
    logic          reg_hwrite;
    logic [2:0]    reg_hsize;
    logic          rdy_q, resp_q, rdy_n, resp_n;
    logic          accept, illegal, cap, commit;
    logic [DW-1:0] rd_word, hold_q, hrdata_c;
    logic [NB-1:0] be;
    logic [4:0]    lane_lo, lane_hi;

    assign accept  = bus.hsel & bus.hready & bus.htrans[1];
    // Too wide for the bus, or address not aligned to the transfer size.
    assign illegal = (32'(bus.hsize) > LB) ||
                     ((bus.haddr[7:0] & ((8'd1 << bus.hsize) - 8'd1)) != 8'd0);

    // Where a new address phase leads, shared by IDLE, ERR2 and a completing ACCESS.
    always_comb begin
        launch_state = ST_IDLE;
        launch_cnt   = '0;
        if (accept) begin
            launch_state = illegal ? ST_ERR1 : ST_ACCESS;
            launch_cnt   = illegal ? '0 : WS;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap     = 1'b0;
        commit  = 1'b0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_n = launch_state;
                cnt_n   = launch_cnt;
                cap     = accept;
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    commit  = reg_hwrite;
                    state_n = launch_state;
                    cnt_n   = launch_cnt;
                    cap     = accept;
                end
            end
            ST_ERR1: state_n = ST_ERR2;
            default: state_n = ST_IDLE;
        endcase
        rdy_n  = !((state_n == ST_ERR1) || ((state_n == ST_ACCESS) && (cnt_n != '0)));
        resp_n = ((state_n == ST_ERR1) || (state_n == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rdy_q      <= 1'b1;
            resp_q     <= HRESP_OKAY;
            hold_q     <= '0;
            reg_haddr  <= '0;
            reg_hwrite <= 1'b0;
            reg_hsize  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rdy_q  <= rdy_n;
            resp_q <= resp_n;
            hold_q <= hrdata_c;
            if (cap) begin
                reg_haddr  <= bus.haddr;
                reg_hwrite <= bus.hwrite;
                reg_hsize  <= bus.hsize;
            end
        end
    end

    // Byte lanes [lo, hi) covered by the stored transfer.
    always_comb begin
        lane_lo = 5'(reg_haddr[LB-1:0]);
        lane_hi = lane_lo + (5'd1 << reg_hsize);
        be      = '0;
        for (int i = 0; i < int'(NB); i++) begin
            be[i] = (5'(i) >= lane_lo) && (5'(i) < lane_hi);
        end
    end

    ahb_sram_array #(.DW(DW), .DEPTH(DEPTH)) u_array (
        .clk   (hclk),
        .we    (commit & ~hreset),
        .be    (be),
        .addr  (reg_haddr[LB +: IW]),
        .wdata (bus.hwdata),
        .rdata (rd_word)
    );

    // Live array word during a read data phase, otherwise the last value seen.
    assign hrdata_c = ((state == ST_ACCESS) && !reg_hwrite) ? rd_word : hold_q;

    assign bus.hrdata    = hrdata_c;
    assign bus.hreadyout = rdy_q;
    assign bus.hresp     = resp_q;

    logic unused;
    assign unused = ^{bus.hburst, bus.htrans[0], reg_haddr};
endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned DEPTH = 16;
    localparam int WS0 = 0;
    localparam int WS1 = 3;

    localparam int K_IDLE  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_NOSEL = 2;
    localparam int K_XFER  = 3;

    typedef struct {
        int          kind;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        bit          chk_lit;
        logic [31:0] lit;
        int          rst_at;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hreset;
    logic        m_sel, m_write;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_trans;
    logic [2:0]  m_size;
    int          dut_sel;

    ahb_sram_slave_if #(.DW(DW), .AW(AW)) if0 ();
    ahb_sram_slave_if #(.DW(DW), .AW(AW)) if1 ();

    ahb_sram_slave #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .hclk(clk), .hreset(hreset), .bus(if0.slave));
    ahb_sram_slave #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .hclk(clk), .hreset(hreset), .bus(if1.slave));

    assign if0.hsel   = m_sel && (dut_sel == 0);
    assign if1.hsel   = m_sel && (dut_sel == 1);
    assign if0.haddr  = m_addr;   assign if1.haddr  = m_addr;
    assign if0.htrans = m_trans;  assign if1.htrans = m_trans;
    assign if0.hwrite = m_write;  assign if1.hwrite = m_write;
    assign if0.hsize  = m_size;   assign if1.hsize  = m_size;
    assign if0.hburst = 3'b000;   assign if1.hburst = 3'b000;
    assign if0.hwdata = m_wdata;  assign if1.hwdata = m_wdata;
    assign if0.hready = if0.hreadyout;
    assign if1.hready = if1.hreadyout;

    wire        a_rdy  = (dut_sel == 1) ? if1.hreadyout : if0.hreadyout;
    wire        a_resp = (dut_sel == 1) ? if1.hresp     : if0.hresp;
    wire [31:0] a_rd   = (dut_sel == 1) ? if1.hrdata    : if0.hrdata;

    int total = 0;
    int bad = 0;

    bit          chk_en = 1'b0;
    logic        exp_rdy, exp_resp;
    bit          exp_rdv, exp_litv;
    logic [31:0] exp_rd, exp_lit;

    logic [31:0] mem [2][DEPTH];
    xfer_t q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Per-cycle compare against the model's expectation for the active slave.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hreadyout", 32'(a_rdy), 32'(exp_rdy));
            check("hresp", 32'(a_resp), 32'(exp_resp));
            if (exp_rdv)  check("hrdata", a_rd, exp_rd);
            if (exp_litv) check("hrdata_literal", a_rd, exp_lit);
        end
    end

    function automatic xfer_t mk(input int kind, input bit wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] data,
                                 input bit cl, input logic [31:0] lit, input int rst_at);
        xfer_t x;
        x.kind = kind; x.wr = wr; x.addr = addr; x.size = size; x.data = data;
        x.chk_lit = cl; x.lit = lit; x.rst_at = rst_at;
        return x;
    endfunction

    function automatic bit is_illegal(input xfer_t h);
        return (h.size > 3'd2) || ((h.addr % (32'd1 << h.size)) != 0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic commit(input int d, input xfer_t h);
        int off;
        int n;
        logic [31:0] w;
        off = int'(h.addr % 4);
        n = 1 << h.size;
        w = mem[d][widx(h.addr)];
        for (int b = off; b < off + n; b++) w[8*b +: 8] = h.data[8*b +: 8];
        mem[d][widx(h.addr)] = w;
    endtask

    task automatic drive(input bit valid, input xfer_t h);
        m_sel = 1'b0; m_trans = HTRANS_IDLE; m_write = 1'b0; m_addr = '0; m_size = '0;
        if (valid) begin
            m_addr = h.addr; m_write = h.wr; m_size = h.size;
            case (h.kind)
                K_IDLE:  begin m_sel = 1'b1; m_trans = HTRANS_IDLE;   end
                K_BUSY:  begin m_sel = 1'b1; m_trans = HTRANS_BUSY;   end
                K_NOSEL: begin m_sel = 1'b0; m_trans = HTRANS_NONSEQ; end
                default: begin m_sel = 1'b1; m_trans = HTRANS_NONSEQ; end
            endcase
        end
    endtask

    // Plays the queue on slave d, one cycle per loop, predicting each cycle's response.
    task automatic run_queue(input int d);
        int ws;
        int dp_left, dp_total, idx, tail;
        bit cur_err, abort, post_rst;
        xfer_t cur, h;
        ws = (d == 0) ? WS0 : WS1;
        dp_left = 0; dp_total = 0; cur_err = 0; post_rst = 0; tail = 0;
        cur = mk(K_IDLE, 0, 0, 0, 0, 0, 0, 0);
        while (q.size() > 0 || dp_left > 0 || tail < 2) begin
            if (q.size() == 0 && dp_left == 0) tail++;
            @(posedge clk); #1;
            hreset = 1'b0;
            abort = 0;
            exp_rdy = 1'b1; exp_resp = 1'b0; exp_rdv = 0; exp_litv = 0;
            if (post_rst) begin exp_rdv = 1; exp_rd = '0; post_rst = 0; end
            if (dp_left > 0) begin
                idx = dp_total - dp_left + 1;
                exp_rdy = (dp_left == 1);
                exp_resp = cur_err;
                if (cur.wr) m_wdata = cur.data;
                if (!cur_err && !cur.wr && dp_left == 1) begin
                    exp_rdv = 1; exp_rd = mem[d][widx(cur.addr)];
                    exp_litv = cur.chk_lit; exp_lit = cur.lit;
                end
                if (!cur_err && cur.wr && cur.rst_at == idx) begin
                    hreset = 1'b1; abort = 1;
                end
            end
            if (q.size() > 0) drive(1, q[0]); else drive(0, cur);
            chk_en = 1'b1;
            if (abort) begin
                dp_left = 0; post_rst = 1;
            end else begin
                if (dp_left > 0) begin
                    dp_left--;
                    if (dp_left == 0 && !cur_err && cur.wr) commit(d, cur);
                end
                if (exp_rdy && q.size() > 0) begin
                    h = q.pop_front();
                    if (h.kind == K_XFER) begin
                        cur = h;
                        cur_err = is_illegal(h);
                        dp_total = cur_err ? 2 : ws + 1;
                        dp_left = dp_total;
                    end
                end
            end
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
    endtask

    task automatic random_queue(input int n);
        xfer_t x;
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            x = mk(K_XFER, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)),
                   3'($urandom_range(0, 2)), $urandom, 0, 0, 0);
            if ($urandom_range(0, 9) == 0) x.size = 3'd3;
            if ($urandom_range(0, 6) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
            if (r == 0) x.kind = K_IDLE;
            else if (r == 1) x.kind = K_BUSY;
            else if (r == 2) x.kind = K_NOSEL;
            q.push_back(x);
        end
    endtask

    initial begin
        hreset = 1'b1; dut_sel = 0; m_wdata = '0;
        drive(0, mk(K_IDLE, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy0", 32'(if0.hreadyout), 32'd1);
        check("rst_resp0", 32'(if0.hresp), 32'd0);
        check("rst_rd0", if0.hrdata, 32'd0);
        check("rst_rdy1", 32'(if1.hreadyout), 32'd1);
        check("rst_resp1", 32'(if1.hresp), 32'd0);
        check("rst_rd1", if1.hrdata, 32'd0);
        @(posedge clk); #1;
        hreset = 1'b0;

        // Known contents for both arrays.
        for (int d = 0; d < 2; d++) begin
            dut_sel = d;
            for (int i = 0; i < int'(DEPTH); i++)
                q.push_back(mk(K_XFER, 1, 32'(4*i), 3'd2, 32'hC0DE0000 | 32'(i), 0, 0, 0));
            run_queue(d);
        end

        // Zero-wait slave: word write/read, byte merge, misaligned half, no-access cycles.
        dut_sel = 0;
        q.push_back(mk(K_XFER, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0, 0));
        q.push_back(mk(K_XFER, 0, 32'h10, 3'd2, 0, 1, 32'hDEADBEEF, 0));
        q.push_back(mk(K_XFER, 1, 32'h10, 3'd2, 32'h11223344, 0, 0, 0));
        q.push_back(mk(K_XFER, 1, 32'h13, 3'd0, 32'hAA000000, 0, 0, 0));
        q.push_back(mk(K_XFER, 0, 32'h10, 3'd2, 0, 1, 32'hAA223344, 0));
        q.push_back(mk(K_XFER, 1, 32'h01, 3'd1, 32'hFFFFFFFF, 0, 0, 0));
        q.push_back(mk(K_XFER, 0, 32'h00, 3'd2, 0, 1, 32'hC0DE0000, 0));
        q.push_back(mk(K_BUSY, 1, 32'h08, 3'd2, 32'hFFFFFFFF, 0, 0, 0));
        q.push_back(mk(K_NOSEL, 1, 32'h08, 3'd2, 32'hFFFFFFFF, 0, 0, 0));
        q.push_back(mk(K_XFER, 0, 32'h08, 3'd2, 0, 1, 32'hC0DE0002, 0));
        q.push_back(mk(K_XFER, 0, 32'h48, 3'd2, 0, 1, 32'hC0DE0002, 0));
        run_queue(0);
        check("model_w4", mem[0][4], 32'hAA223344);
        check("model_w0", mem[0][0], 32'hC0DE0000);

        // Three-wait slave: back-to-back reads, reset in the 2nd wait cycle of a write.
        dut_sel = 1;
        q.push_back(mk(K_XFER, 0, 32'h00, 3'd2, 0, 1, 32'hC0DE0000, 0));
        q.push_back(mk(K_XFER, 0, 32'h04, 3'd2, 0, 1, 32'hC0DE0001, 0));
        q.push_back(mk(K_XFER, 1, 32'h20, 3'd2, 32'h12345678, 0, 0, 2));
        q.push_back(mk(K_XFER, 0, 32'h20, 3'd2, 0, 1, 32'hC0DE0008, 0));
        q.push_back(mk(K_XFER, 1, 32'h06, 3'd1, 32'hBEEF0000, 0, 0, 0));
        q.push_back(mk(K_XFER, 0, 32'h04, 3'd2, 0, 1, 32'hBEEF0001, 0));
        run_queue(1);
        check("model_w8", mem[1][8], 32'hC0DE0008);

        // Randomised traffic on both slaves.
        for (int d = 0; d < 2; d++) begin
            dut_sel = d;
            random_queue(150);
            run_queue(d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
